divider_seq_n: RTL and testbench



---
 rtl/div_defs.sv | 13 +
 rtl/sub_step_n.sv | 35 +++
 rtl/divider_seq_n.sv | 133 +++++++++++++
 tb/tb_divider_seq_n.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/div_defs.sv
// Shared definitions for the sequential restoring divider: FSM state encodings
// and the default operand width.
package div_defs;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_step_n.sv
// One restoring-division step: a ripple-borrow subtractor built from
// full-subtractor cells, followed by a restore mux.
module sub_step_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   shifted,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] sub_b;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] borrow;

    assign sub_b     = {1'b0, divisor};
    assign borrow[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i <= WIDTH; i++) begin : g_cell
            assign diff[i] = shifted[i] ^ sub_b[i] ^ borrow[i];
            // The top cell's borrow-out is not needed: the sign of the trial
            // difference already tells us whether to restore.
            if (i < WIDTH) begin : g_bo
                assign borrow[i+1] = (~shifted[i] & sub_b[i]) |
                                     (~(shifted[i] ^ sub_b[i]) & borrow[i]);
            end
        end
    endgenerate

    assign q_bit    = ~diff[WIDTH];
    assign next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider_seq_n.sv
// Sequential unsigned restoring divider, one shift-and-subtract step per clock,
// with a start/ready/done handshake and a divide-by-zero shortcut.
module divider_seq_n
    import div_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] next_rem;
    logic             q_bit;

    assign shifted = {rem_q, q_q[WIDTH-1]};

    sub_step_n #(.WIDTH(WIDTH)) u_step (
        .shifted  (shifted),
        .divisor  (dvsr_q),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        q_d         = q_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvsr_d  = divisor;
                    ready_d = 1'b0;
                    if (divisor != '0) begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                        q_d     = dividend;
                        cnt_d   = CW'(WIDTH - 1);
                        dbz_d   = 1'b0;
                    end else begin
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                rem_d = next_rem;
                q_d   = {q_q[WIDTH-2:0], q_bit};
                if (cnt_q == '0) begin
                    // Results are published only here, never mid-division.
                    state_d     = ST_DONE;
                    quotient_d  = {q_q[WIDTH-2:0], q_bit};
                    remainder_d = next_rem;
                    done_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            q_q         <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq_n.sv
// Self-checking bench for divider_seq_n: directed cases, handshake corner cases
// and random traffic, checked through an expected-result scoreboard.
module tb_divider_seq_n;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    logic [W-1:0] exp_quo_q[$];
    logic [W-1:0] exp_rem_q[$];
    logic         exp_dbz_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    divider_seq_n #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference model: pushes the expected outcome of one accepted request.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) begin
            exp_quo_q.push_back('1);
            exp_rem_q.push_back(a);
            exp_dbz_q.push_back(1'b1);
        end else begin
            exp_quo_q.push_back(a / b);
            exp_rem_q.push_back(a % b);
            exp_dbz_q.push_back(1'b0);
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (exp_quo_q.size() == 0) begin
                check_eq("spurious_done", 1, 0);
            end else begin
                check_eq("quotient", quotient, exp_quo_q.pop_front());
                check_eq("remainder", remainder, exp_rem_q.pop_front());
                check_eq("div_by_zero", div_by_zero, exp_dbz_q.pop_front());
            end
        end
    end

    // Drive one request; optionally inject an ignored start pulse at cycle glitch_cyc.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_lat, input int glitch_cyc);
        bit got_done;
        logic [31:0] q_exp, r_exp;
        q_exp = (b == '0) ? 32'hFF : 32'(a / b);
        r_exp = (b == '0) ? 32'(a) : 32'(a % b);
        @(negedge clk);
        for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
        check_eq("ready_before_start", ready, 1);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        push_exp(a, b);
        @(posedge clk);
        got_done = 0;
        for (int c = 1; c <= 40 && !got_done; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == glitch_cyc) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd2;
            end
            check_eq("ready_busy", ready, 0);
            if (done) begin
                got_done = 1;
                check_eq("latency", c, exp_lat);
            end
        end
        start = 1'b0;
        if (!got_done) check_eq("done_timeout", 0, 1);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("ready_after_done", ready, 1);
        check_eq("quotient_hold", quotient, q_exp);
        check_eq("remainder_hold", remainder, r_exp);
    endtask

    initial begin
        int first_c;
        int second_c;
        int done_before;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_quotient", quotient, 0);
        check_eq("rst_remainder", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        run_div(8'd100, 8'd7, 9, 0);
        run_div(8'd255, 8'd1, 9, 0);
        run_div(8'd5, 8'd9, 9, 0);
        run_div(8'd255, 8'd255, 9, 0);
        run_div(8'd42, 8'd0, 1, 0);
        check_eq("dbz_held", div_by_zero, 1);
        run_div(8'd42, 8'd6, 9, 0);
        check_eq("dbz_cleared", div_by_zero, 0);

        // start pulse during RUN is ignored
        run_div(8'd200, 8'd3, 9, 4);

        // start held high: back-to-back divisions
        @(negedge clk);
        first_c  = 0;
        second_c = 0;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        push_exp(8'd200, 8'd3);
        @(posedge clk);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done) begin
                if (first_c == 0) first_c = c;
                else second_c = c;
            end
            if (c == 9) begin
                dividend = 8'd9;
                divisor  = 8'd2;
            end
            if (c == 10) begin
                check_eq("b2b_ready", ready, 1);
                push_exp(8'd9, 8'd2);
            end
            if (c == 11) start = 1'b0;
        end
        check_eq("b2b_first_done", first_c, 9);
        check_eq("b2b_second_done", second_c, 19);
        check_eq("b2b_quotient", quotient, 4);
        check_eq("b2b_remainder", remainder, 1);

        // reset in the middle of a division
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        done_before = n_done;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", ready, 1);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_quotient", quotient, 0);
        check_eq("mid_rst_remainder", remainder, 0);
        check_eq("mid_rst_dbz", div_by_zero, 0);
        repeat (10) @(negedge clk);
        check_eq("mid_rst_no_done", n_done, done_before);
        rst_n = 1'b1;
        run_div(8'd100, 8'd7, 9, 0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            run_div(ra, rb, (rb == '0) ? 1 : 9, 0);
        end

        repeat (3) @(negedge clk);
        check_eq("queue_empty", exp_quo_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
